// File: rtl/ar_muxn_scan.sv
// N-channel word multiplexer with manual select or round-robin scan,
// feeding a one-entry registered output slot with valid/ready drain.
module ar_muxn_scan #(
    parameter int SEL_W = 2,
    parameter int DW    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(2**SEL_W)*DW-1:0]  din,
    input  logic [(2**SEL_W)-1:0]     ch_valid,
    output logic [(2**SEL_W)-1:0]     ch_ack,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      enable,
    output logic [DW-1:0]             dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    localparam int N_CH = 2**SEL_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    dout_q;
    logic [SEL_W-1:0] ch_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] idx;
    logic [DW-1:0]    gdata;
    logic             found;
    logic             slot_free;
    logic             cap;

    // Descending walk so the smallest offset from ptr wins; the
    // SEL_W-bit add wraps modulo N_CH for free.
    always_comb begin
        found = 1'b0;
        gidx  = sel;
        idx   = '0;
        if (mode) begin
            gidx = ptr_q;
            for (int i = N_CH - 1; i >= 0; i--) begin
                idx = ptr_q + SEL_W'(i);
                if (ch_valid[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end else begin
            found = ch_valid[sel];
        end
    end

    assign slot_free = (state_q == EMPTY) | dout_ready;
    assign cap       = ~rst & enable & slot_free & found;

    always_comb begin
        ch_ack = '0;
        if (cap) begin
            ch_ack[gidx] = 1'b1;
        end
    end

    always_comb begin
        gdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gidx == SEL_W'(k)) begin
                gdata = din[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (cap) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (cap) begin
                    state_d = FULL;
                end else if (dout_ready) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            dout_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                dout_q <= gdata;
                ch_q   <= gidx;
                if (mode) begin
                    ptr_q <= gidx + SEL_W'(1);
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = ch_q;
    assign dout_valid = (state_q == FULL);

endmodule

// File: tb/tb_ar_muxn_scan.sv
// Randomized and directed bench for ar_muxn_scan against a
// transaction-level model of the output slot and scan pointer.
module tb_ar_muxn_scan;

    localparam int SEL_W = 2;
    localparam int DW    = 8;
    localparam int N     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*DW-1:0]  din;
    logic [N-1:0]     ch_valid;
    logic [N-1:0]     ch_ack;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             enable;
    logic [DW-1:0]    dout;
    logic [SEL_W-1:0] dout_ch;
    logic             dout_valid;
    logic             dout_ready;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit       m_valid;
    bit [7:0] m_dout;
    int       m_ch;
    int       m_ptr;

    // per-cycle observations
    logic [N-1:0] obs_ack;
    logic [N-1:0] exp_ack;

    ar_muxn_scan #(.SEL_W(SEL_W), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .ch_valid   (ch_valid),
        .ch_ack     (ch_ack),
        .sel        (sel),
        .mode       (mode),
        .enable     (enable),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    function automatic void model_pick(output bit found, output int g);
        found = 1'b0;
        g = 0;
        if (!mode) begin
            g = int'(sel);
            found = ch_valid[g];
        end else begin
            for (int o = 0; o < N; o++) begin
                int c;
                c = (m_ptr + o) % N;
                if (!found && ch_valid[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    function automatic bit model_cap(output int g);
        bit found;
        model_pick(found, g);
        return !rst && enable && (!m_valid || dout_ready) && found;
    endfunction

    task automatic tick();
        int g;
        bit c;
        @(negedge clk);
        obs_ack = ch_ack;
        c = model_cap(g);
        exp_ack = c ? N'(1 << g) : '0;
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_dout  = 0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (c) begin
            m_valid = 1;
            m_dout  = din[g*DW +: DW];
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (dout_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic set_din_scan();
        for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        rst = 1; enable = 1; mode = 1; dout_ready = 1;
        ch_valid = 4'b1111; din = $urandom; sel = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs_ack !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_ack got=%b exp=0000", obs_ack);
            end
        end
        n_cmp++;
        if (dout !== 8'h00 || dout_ch !== 2'd0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out got=%h/%0d/%b exp=00/0/0",
                     dout, dout_ch, dout_valid);
        end
        rst = 0;
    endtask

    task automatic test_manual();
        mode = 0; sel = 2; ch_valid = 4'b0100; enable = 1;
        dout_ready = 1; din = $urandom; din[2*DW +: DW] = 8'hA5;
        tick();
        n_cmp++;
        if (obs_ack !== 4'b0100) begin
            n_err++;
            $display("FAIL manual_ack got=%b exp=0100", obs_ack);
        end
        n_cmp++;
        if (dout !== 8'hA5 || dout_ch !== 2'd2 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL manual_out got=%h/%0d/%b exp=a5/2/1",
                     dout, dout_ch, dout_valid);
        end
        sel = 1;
        din = $urandom;
        tick();
        n_cmp++;
        if (obs_ack !== 4'b0000 || dout_valid !== 1'b0 || dout !== 8'hA5) begin
            n_err++;
            $display("FAIL manual_nocand got=%b/%b/%h exp=0000/0/a5",
                     obs_ack, dout_valid, dout);
        end
    endtask

    task automatic test_scan_fair();
        int seq [5] = '{0, 1, 2, 3, 0};
        int wrp [2] = '{3, 0};
        mode = 1; ch_valid = 4'b1111; enable = 1; dout_ready = 1;
        set_din_scan();
        foreach (seq[i]) begin
            tick();
            n_cmp++;
            if (dout_ch !== 2'(seq[i]) || dout !== 8'(8'h10 + seq[i])
                || dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL scan_seq%0d got=%0d/%h exp=%0d/%h",
                         i, dout_ch, dout, seq[i], 8'h10 + seq[i]);
            end
        end
        ch_valid = 4'b1001;
        foreach (wrp[i]) begin
            tick();
            n_cmp++;
            if (dout_ch !== 2'(wrp[i]) || obs_ack !== N'(1 << wrp[i])) begin
                n_err++;
                $display("FAIL scan_wrap%0d got=%0d/%b exp=%0d",
                         i, dout_ch, obs_ack, wrp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d2;
        mode = 0; sel = 1; ch_valid = 4'b0010; enable = 1; dout_ready = 1;
        din = $urandom; din[1*DW +: DW] = 8'h11;
        tick();
        dout_ready = 0;
        for (int i = 0; i < 5; i++) begin
            din = $urandom; ch_valid = 4'($urandom);
            mode = 1'($urandom); sel = 2'($urandom); enable = 1'($urandom);
            tick();
            n_cmp++;
            if (obs_ack !== 4'b0000 || dout !== 8'h11 || dout_ch !== 2'd1
                || dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=0000/11/1/1",
                         i, obs_ack, dout, dout_ch, dout_valid);
            end
        end
        d2 = 8'($urandom);
        mode = 0; sel = 2; ch_valid = 4'b0100; enable = 1; dout_ready = 1;
        din = $urandom; din[2*DW +: DW] = d2;
        tick();
        n_cmp++;
        if (obs_ack !== 4'b0100 || dout !== d2 || dout_ch !== 2'd2
            || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_replace got=%b/%h/%0d/%b exp=0100/%h/2/1",
                     obs_ack, dout, dout_ch, dout_valid, d2);
        end
    endtask

    task automatic test_enable_drain();
        logic [7:0] held;
        held = dout;
        enable = 0; dout_ready = 1; mode = 1; ch_valid = 4'b1111;
        set_din_scan();
        tick();
        n_cmp++;
        if (obs_ack !== 4'b0000 || dout_valid !== 1'b0 || dout !== held) begin
            n_err++;
            $display("FAIL drain got=%b/%b/%h exp=0000/0/%h",
                     obs_ack, dout_valid, dout, held);
        end
        // scan pointer was left at 1 by the wrap sequence
        enable = 1;
        tick();
        n_cmp++;
        if (dout_ch !== 2'd1 || dout !== 8'h11 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL resume got=%0d/%h/%b exp=1/11/1",
                     dout_ch, dout, dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1; enable = 1; dout_ready = 1; ch_valid = 4'b0100;
        set_din_scan();
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || obs_ack !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid got=%b/%h/%b exp=0/00/0000",
                     dout_valid, dout, obs_ack);
        end
        ch_valid = 4'b1111;
        tick();
        n_cmp++;
        if (dout_ch !== 2'd0 || obs_ack !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_ptr got=%0d/%b exp=0/0001", dout_ch, obs_ack);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 29) == 0);
            din        = $urandom;
            ch_valid   = 4'($urandom);
            sel        = 2'($urandom);
            mode       = ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 4) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++;
            if (obs_ack !== exp_ack || dout_valid !== m_valid
                || dout !== m_dout || dout_ch !== 2'(m_ch)) begin
                n_err++;
                $display("FAIL rand%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d",
                         i, obs_ack, dout_valid, dout, dout_ch,
                         exp_ack, m_valid, m_dout, m_ch);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; din = '0; ch_valid = '0; sel = '0;
        mode = 0; enable = 0; dout_ready = 0;
        m_valid = 0; m_dout = 0; m_ch = 0; m_ptr = 0;
        #1;
        test_reset();
        test_manual();
        test_scan_fair();
        test_backpressure();
        test_enable_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ar_muxn_scan.md
AR_MUXN_SCAN -- requirements
Module: ar_muxn_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; channel count N_CH = 2**SEL_W, minimum 1.
REQ-002 Parameter DW, default 8: data width per channel, minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-006 ch_valid  input  N_CH  bit k high = channel k offers a word.
REQ-007 ch_ack  output  N_CH  one-hot combinational pulse: channel k's word is captured this cycle.
REQ-008 sel  input  SEL_W  channel select, used in manual mode only.
REQ-009 mode  input  1  0 = manual (sel-driven), 1 = scan (round-robin).
REQ-010 enable  input  1  1 = captures permitted; 0 = no new capture.
REQ-011 dout  output  DW  registered selected data.
REQ-012 dout_ch  output  SEL_W  index of the channel that produced dout.
REQ-013 dout_valid  output  1  dout/dout_ch hold an unconsumed word.
REQ-014 dout_ready  input  1  downstream accepts the word when dout_valid & dout_ready.

Function
REQ-015 Output stage SHALL be a one-entry register with two states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-016 slot_free = ~dout_valid | dout_ready; a capture SHALL occur only when enable=1, slot_free=1 and a candidate channel exists.
REQ-017 Manual mode: the candidate SHALL be channel sel, and only if ch_valid[sel]=1; other channels are ignored.
REQ-018 Scan mode: the candidate SHALL be the first channel with ch_valid=1, searching ptr, ptr+1, ... modulo N_CH.
REQ-019 On a scan-mode capture of channel g, ptr SHALL become (g+1) mod N_CH (wrap from N_CH-1 to 0); otherwise ptr SHALL hold.
REQ-020 Manual-mode captures SHALL NOT change ptr; a mode change SHALL take effect at the next capture decision, with no flush.
REQ-021 On capture of channel g: next cycle dout=din[g], dout_ch=g, dout_valid=1; ch_ack[g]=1 in the capture cycle; latency 1 cycle.
REQ-022 ch_ack SHALL be all-zero in any cycle without a capture; at most one bit SHALL be set.
REQ-023 FULL with dout_ready=1 and a capture in the same cycle: new word SHALL replace the old one with dout_valid remaining 1 (throughput 1 word/cycle).
REQ-024 FULL with dout_ready=1 and no capture: dout_valid SHALL drop to 0 next cycle; dout and dout_ch SHALL hold their last values.
REQ-025 FULL with dout_ready=0: dout, dout_ch, dout_valid SHALL be stable regardless of enable, mode, sel, ch_valid or din.
REQ-026 enable=0 SHALL block captures only; a held word SHALL still drain via dout_ready.
REQ-027 No candidate (all relevant ch_valid=0) SHALL behave as enable=0 for that cycle.
REQ-028 dout SHALL depend only on registered state, with no combinational path from din to dout.

Reset
REQ-029 While rst=1 at a clock edge: dout=0, dout_ch=0, dout_valid=0, ptr=0; ch_ack SHALL be all-zero while rst=1.
REQ-030 rst asserted mid-transfer SHALL discard the held word; the first capture may occur in the cycle after rst deasserts.

Verification (SEL_W=2, DW=8)
REQ-031 Reset: rst=1 for 2 cycles with din/ch_valid active -> dout=0x00, dout_ch=0, dout_valid=0, ch_ack=0000.
REQ-032 Manual: mode=0, sel=2, ch_valid=0100, din ch2=0xA5, dout_ready=1, enable=1 -> ch_ack=0100 same cycle; next cycle dout=0xA5, dout_ch=2, dout_valid=1; sel=1 with ch_valid[1]=0 -> no capture.
REQ-033 Scan fairness: mode=1, ch_valid=1111, din ch k=0x10+k, dout_ready=1 -> dout_ch sequence 0,1,2,3,0 on consecutive cycles; with ch_valid=1001 and ptr=1 -> grants 3 then 0 (wrap).
REQ-034 Backpressure: FULL with 0x11 from ch1, dout_ready=0 for 5 cycles while din changes -> dout stays 0x11, ch_ack=0000; dout_ready=1 with a ch2 candidate -> dout=ch2 data next cycle, dout_valid stays 1.
REQ-035 Enable/drain: FULL, enable=0, dout_ready=1 -> dout_valid=0 next cycle, dout holds value, no ch_ack; enable=1 -> capture resumes from preserved ptr.
REQ-036 Reset mid-operation: scan with ptr=3 and dout_valid=1, pulse rst for 1 cycle -> dout_valid=0, ptr=0; next scan grant with ch_valid=1111 -> channel 0.
